// File: rtl/phy_regfile_pkg.sv
// phy_regfile shared definitions
// default geometry, derived widths, unused-id sentinel, bitmap type
package phy_regfile_pkg;

  localparam int PHY_REG_NUM_DEF    = 64;
  localparam int REG_DATA_WIDTH_DEF = 32;
  localparam int READ_PORTS_DEF     = 8;
  localparam int WB_PORTS_DEF       = 4;
  localparam int COMMIT_PORTS_DEF   = 4;
  localparam int CKPT_NUM_DEF       = 4;

  localparam int ID_W_DEF   = $clog2(PHY_REG_NUM_DEF);
  localparam int CKPT_W_DEF = $clog2(CKPT_NUM_DEF);

  // read ports carrying this id are idle
  localparam logic [ID_W_DEF-1:0] RD_UNUSED = '1;

  typedef logic [PHY_REG_NUM_DEF-1:0] vmap_t;

endpackage

// File: rtl/phy_regfile_valid_ckpt.sv
// phy_regfile valid bitmap with checkpoint slots
// restore -> invalidate -> writeback set, save captures the result
module phy_regfile_valid_ckpt
  import phy_regfile_pkg::*;
#(
  parameter int PHY_REG_NUM  = PHY_REG_NUM_DEF,
  parameter int WB_PORTS     = WB_PORTS_DEF,
  parameter int COMMIT_PORTS = COMMIT_PORTS_DEF,
  parameter int CKPT_NUM     = CKPT_NUM_DEF,
  parameter int ID_W         = $clog2(PHY_REG_NUM),
  parameter int CKPT_W       = $clog2(CKPT_NUM)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ID_W-1:0]         wb_id_i [WB_PORTS],
  input  logic [WB_PORTS-1:0]     wb_we_i,
  input  logic [ID_W-1:0]         commit_id_i [COMMIT_PORTS],
  input  logic [COMMIT_PORTS-1:0] commit_invalid_i,
  input  logic [ID_W-1:0]         flush_id_i,
  input  logic                    flush_invalid_i,
  input  logic                    ckpt_save_i,
  input  logic [CKPT_W-1:0]       ckpt_save_id_i,
  input  logic                    ckpt_restore_i,
  input  logic [CKPT_W-1:0]       ckpt_restore_id_i,
  output logic [PHY_REG_NUM-1:0]  valid_map_o
);

  logic [PHY_REG_NUM-1:0] valid_q;
  logic [PHY_REG_NUM-1:0] valid_d;
  logic [PHY_REG_NUM-1:0] ckpt_q [CKPT_NUM];

  // next bitmap: pick base, clear invalidates, then writebacks win
  always_comb begin
    if (ckpt_restore_i) begin
      valid_d = ckpt_q[ckpt_restore_id_i];
    end else begin
      valid_d = valid_q;
    end
    for (int i = 0; i < COMMIT_PORTS; i++) begin
      if (commit_invalid_i[i]) begin
        valid_d[commit_id_i[i]] = 1'b0;
      end
    end
    if (flush_invalid_i) begin
      valid_d[flush_id_i] = 1'b0;
    end
    for (int k = 0; k < WB_PORTS; k++) begin
      if (wb_we_i[k]) begin
        valid_d[wb_id_i[k]] = 1'b1;
      end
    end
  end

  // live bitmap and snapshot slots
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int c = 0; c < CKPT_NUM; c++) begin
        ckpt_q[c] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      if (ckpt_save_i) begin
        ckpt_q[ckpt_save_id_i] <= valid_d;
      end
    end
  end

  assign valid_map_o = valid_q;

endmodule

// File: rtl/phy_regfile_mp.sv
// phy_regfile_mp: multi-port physical register file
// data array, writeback-to-read bypass, checkpointed valid bitmap
module phy_regfile_mp
  import phy_regfile_pkg::*;
#(
  parameter int PHY_REG_NUM    = PHY_REG_NUM_DEF,
  parameter int REG_DATA_WIDTH = REG_DATA_WIDTH_DEF,
  parameter int READ_PORTS     = READ_PORTS_DEF,
  parameter int WB_PORTS       = WB_PORTS_DEF,
  parameter int COMMIT_PORTS   = COMMIT_PORTS_DEF,
  parameter int CKPT_NUM       = CKPT_NUM_DEF,
  parameter int ID_W           = $clog2(PHY_REG_NUM),
  parameter int CKPT_W         = $clog2(CKPT_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ID_W-1:0]           rd_id [READ_PORTS],
  output logic [REG_DATA_WIDTH-1:0] rd_data [READ_PORTS],
  output logic                      rd_data_valid [READ_PORTS],
  input  logic [ID_W-1:0]           wb_id [WB_PORTS],
  input  logic [REG_DATA_WIDTH-1:0] wb_data [WB_PORTS],
  input  logic [WB_PORTS-1:0]       wb_we,
  input  logic [ID_W-1:0]           commit_id [COMMIT_PORTS],
  input  logic [COMMIT_PORTS-1:0]   commit_invalid,
  input  logic [ID_W-1:0]           flush_id,
  input  logic                      flush_invalid,
  input  logic                      ckpt_save,
  input  logic [CKPT_W-1:0]         ckpt_save_id,
  input  logic                      ckpt_restore,
  input  logic [CKPT_W-1:0]         ckpt_restore_id,
  output logic [PHY_REG_NUM-1:0]    valid_map
);

  logic [REG_DATA_WIDTH-1:0] data_q [PHY_REG_NUM];
  logic [PHY_REG_NUM-1:0]    valid_q;

  phy_regfile_valid_ckpt #(
    .PHY_REG_NUM  (PHY_REG_NUM),
    .WB_PORTS     (WB_PORTS),
    .COMMIT_PORTS (COMMIT_PORTS),
    .CKPT_NUM     (CKPT_NUM),
    .ID_W         (ID_W),
    .CKPT_W       (CKPT_W)
  ) u_valid (
    .clk_i             (clk),
    .rst_ni            (rst),
    .wb_id_i           (wb_id),
    .wb_we_i           (wb_we),
    .commit_id_i       (commit_id),
    .commit_invalid_i  (commit_invalid),
    .flush_id_i        (flush_id),
    .flush_invalid_i   (flush_invalid),
    .ckpt_save_i       (ckpt_save),
    .ckpt_save_id_i    (ckpt_save_id),
    .ckpt_restore_i    (ckpt_restore),
    .ckpt_restore_id_i (ckpt_restore_id),
    .valid_map_o       (valid_q)
  );

  assign valid_map = valid_q;

  // data array; ascending port order lets the highest port win
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < PHY_REG_NUM; r++) begin
        data_q[r] <= '0;
      end
    end else begin
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wb_we[k]) begin
          data_q[wb_id[k]] <= wb_data[k];
        end
      end
    end
  end

  // read muxes: array value, overridden by the highest matching wb port
  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_data[p]       = '0;
      rd_data_valid[p] = 1'b0;
      if (rst && !(&rd_id[p])) begin
        rd_data[p]       = data_q[rd_id[p]];
        rd_data_valid[p] = valid_q[rd_id[p]];
        for (int k = 0; k < WB_PORTS; k++) begin
          if (wb_we[k] && (wb_id[k] == rd_id[p])) begin
            rd_data[p]       = wb_data[k];
            rd_data_valid[p] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_phy_regfile_mp.sv
// tb_phy_regfile_mp: scoreboard bench for phy_regfile_mp
// expected reads queued with stimulus, drained after settling
module tb_phy_regfile_mp;
  import phy_regfile_pkg::*;

  localparam int NR = READ_PORTS_DEF;
  localparam int NW = WB_PORTS_DEF;
  localparam int NC = COMMIT_PORTS_DEF;
  localparam int IW = ID_W_DEF;
  localparam int CW = CKPT_W_DEF;
  localparam int DW = REG_DATA_WIDTH_DEF;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] rd_id [NR];
  logic [DW-1:0] rd_data [NR];
  logic          rd_data_valid [NR];
  logic [IW-1:0] wb_id [NW];
  logic [DW-1:0] wb_data [NW];
  logic [NW-1:0] wb_we;
  logic [IW-1:0] commit_id [NC];
  logic [NC-1:0] commit_invalid;
  logic [IW-1:0] flush_id;
  logic          flush_invalid;
  logic          ckpt_save;
  logic [CW-1:0] ckpt_save_id;
  logic          ckpt_restore;
  logic [CW-1:0] ckpt_restore_id;
  vmap_t         valid_map;

  typedef struct {
    string         tag;
    int            port;
    logic [DW-1:0] data;
    logic          vld;
  } rd_exp_t;

  rd_exp_t sb [$];
  int      n_chk = 0;
  int      n_err = 0;

  always #5 clk = ~clk;

  phy_regfile_mp dut (
    .clk             (clk),
    .rst             (rst),
    .rd_id           (rd_id),
    .rd_data         (rd_data),
    .rd_data_valid   (rd_data_valid),
    .wb_id           (wb_id),
    .wb_data         (wb_data),
    .wb_we           (wb_we),
    .commit_id       (commit_id),
    .commit_invalid  (commit_invalid),
    .flush_id        (flush_id),
    .flush_invalid   (flush_invalid),
    .ckpt_save       (ckpt_save),
    .ckpt_save_id    (ckpt_save_id),
    .ckpt_restore    (ckpt_restore),
    .ckpt_restore_id (ckpt_restore_id),
    .valid_map       (valid_map)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < NR; i++) rd_id[i] = RD_UNUSED;
    for (int k = 0; k < NW; k++) begin
      wb_id[k]   = '0;
      wb_data[k] = '0;
    end
    for (int i = 0; i < NC; i++) commit_id[i] = '0;
    wb_we           = '0;
    commit_invalid  = '0;
    flush_id        = '0;
    flush_invalid   = 1'b0;
    ckpt_save       = 1'b0;
    ckpt_save_id    = '0;
    ckpt_restore    = 1'b0;
    ckpt_restore_id = '0;
  endtask

  task automatic expect_rd(input string tag, input int port,
                           input logic [DW-1:0] d, input logic v);
    rd_exp_t e;
    e.tag  = tag;
    e.port = port;
    e.data = d;
    e.vld  = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    rd_exp_t e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_d"}, 64'(rd_data[e.port]), 64'(e.data));
      chk({e.tag, "_v"}, 64'(rd_data_valid[e.port]), 64'(e.vld));
    end
  endtask

  task automatic wb(input int k, input logic [IW-1:0] id,
                    input logic [DW-1:0] d);
    wb_we[k]   = 1'b1;
    wb_id[k]   = id;
    wb_data[k] = d;
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  function automatic vmap_t b(input int i);
    vmap_t m;
    m    = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  initial begin
    rst = 1'b0;
    idle();
    #2;
    rd_id[0] = 6'd0;
    rd_id[1] = 6'd5;
    rd_id[2] = 6'd62;
    wb(0, 6'd5, 32'hFFFF_FFFF);
    expect_rd("rst_id0", 0, '0, 1'b0);
    expect_rd("rst_id5", 1, '0, 1'b0);
    expect_rd("rst_id62", 2, '0, 1'b0);
    expect_rd("rst_id63", 3, '0, 1'b0);
    drain();
    chk("rst_vmap", valid_map, '0);
    tick();
    rst = 1'b1;
    tick();

    rd_id[0] = 6'd5;
    wb(0, 6'd5, 32'hDEAD_BEEF);
    expect_rd("byp5", 0, 32'hDEAD_BEEF, 1'b1);
    drain();
    tick();
    rd_id[0] = 6'd5;
    expect_rd("arr5", 0, 32'hDEAD_BEEF, 1'b1);
    drain();
    chk("vmap5", valid_map, b(5));

    wb(1, 6'd9, 32'h11);
    wb(3, 6'd9, 32'h33);
    rd_id[2] = 6'd9;
    expect_rd("byp9", 2, 32'h33, 1'b1);
    expect_rd("unused7", 7, '0, 1'b0);
    drain();
    tick();
    rd_id[2] = 6'd9;
    expect_rd("arr9", 2, 32'h33, 1'b1);
    drain();

    wb(0, 6'd63, 32'hAB);
    rd_id[1] = 6'd63;
    expect_rd("sent63", 1, '0, 1'b0);
    drain();
    tick();
    chk("vmap63", valid_map, b(5) | b(9) | b(63));

    commit_invalid[0] = 1'b1;
    commit_id[0]      = 6'd5;
    wb(2, 6'd5, 32'h77);
    tick();
    rd_id[0] = 6'd5;
    expect_rd("wbwin5", 0, 32'h77, 1'b1);
    drain();
    commit_invalid[0] = 1'b1;
    commit_id[0]      = 6'd5;
    tick();
    rd_id[0] = 6'd5;
    expect_rd("inv5", 0, 32'h77, 1'b0);
    drain();
    chk("vmap_inv", valid_map, b(9) | b(63));

    wb(0, 6'd1, 32'h1);
    wb(1, 6'd2, 32'h2);
    tick();
    ckpt_save    = 1'b1;
    ckpt_save_id = 2'd2;
    tick();
    flush_invalid     = 1'b1;
    flush_id          = 6'd1;
    commit_invalid[0] = 1'b1;
    commit_id[0]      = 6'd2;
    commit_invalid[1] = 1'b1;
    commit_id[1]      = 6'd2;
    tick();
    chk("vmap_fl", valid_map, b(9) | b(63));
    ckpt_restore    = 1'b1;
    ckpt_restore_id = 2'd2;
    wb(0, 6'd3, 32'h3);
    tick();
    chk("vmap_rs", valid_map, b(1) | b(2) | b(3) | b(9) | b(63));

    ckpt_restore      = 1'b1;
    ckpt_restore_id   = 2'd2;
    ckpt_save         = 1'b1;
    ckpt_save_id      = 2'd2;
    commit_invalid[0] = 1'b1;
    commit_id[0]      = 6'd9;
    tick();
    chk("vmap_sr", valid_map, b(1) | b(2) | b(63));
    ckpt_restore    = 1'b1;
    ckpt_restore_id = 2'd0;
    tick();
    chk("vmap_s0", valid_map, '0);
    ckpt_restore    = 1'b1;
    ckpt_restore_id = 2'd2;
    rd_id[4]        = 6'd2;
    expect_rd("pre_rs2", 4, 32'h2, 1'b0);
    drain();
    tick();
    chk("vmap_s2", valid_map, b(1) | b(2) | b(63));

    rd_id[0] = 6'd1;
    rd_id[1] = 6'd2;
    rd_id[2] = 6'd9;
    #2;
    rst = 1'b0;
    expect_rd("arst1", 0, '0, 1'b0);
    expect_rd("arst2", 1, '0, 1'b0);
    expect_rd("arst9", 2, '0, 1'b0);
    drain();
    chk("vmap_arst", valid_map, '0);
    tick();
    rst = 1'b1;
    ckpt_restore    = 1'b1;
    ckpt_restore_id = 2'd2;
    tick();
    chk("vmap_post", valid_map, '0);
    rd_id[3] = 6'd9;
    expect_rd("post9", 3, '0, 1'b0);
    drain();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
